// File: rtl/cam_cfg_pkg.sv
// Shared constants for the camera configuration sequencer: FSM state codes and ROM entry layout.
// The BACKOFF state only exists when CAM_CFG_RETRY_EN is defined.
package cam_cfg_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] ST_RST_LOW  = 4'd1;
  localparam logic [STATE_W-1:0] ST_PWR_WAIT = 4'd2;
  localparam logic [STATE_W-1:0] ST_FETCH    = 4'd3;
  localparam logic [STATE_W-1:0] ST_DECODE   = 4'd4;
  localparam logic [STATE_W-1:0] ST_ISSUE    = 4'd5;
  localparam logic [STATE_W-1:0] ST_DLY      = 4'd6;
  localparam logic [STATE_W-1:0] ST_NEXT     = 4'd7;
  localparam logic [STATE_W-1:0] ST_DONE     = 4'd8;
  localparam logic [STATE_W-1:0] ST_ERROR    = 4'd9;
`ifdef CAM_CFG_RETRY_EN
  localparam logic [STATE_W-1:0] ST_BACKOFF  = 4'd10;
`endif

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [7:0]  DELAY_ADDR = 8'hFF;

  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  function automatic logic [7:0] entry_addr(input logic [15:0] entry);
    return entry[ADDR_HI:ADDR_LO];
  endfunction

  function automatic logic [7:0] entry_data(input logic [15:0] entry);
    return entry[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/cam_cfg_sequencer_if.sv
// Request/acknowledge link between the configuration sequencer and the SCCB byte engine.
interface cam_cfg_sequencer_if;

  logic       req;
  logic [7:0] addr;
  logic [7:0] data;
  logic       ack;
  logic       nack;

  modport master (output req, addr, data, input ack, nack);
  modport slave  (input req, addr, data, output ack, nack);

endinterface

// File: rtl/cam_cfg_rom.sv
// OV-series bring-up register table, synchronous read with one cycle of latency.
// Addresses past the table return the END marker.
module cam_cfg_rom
  import cam_cfg_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  output logic [15:0]      entry
);

  localparam int DEPTH = 8;

  // Soft reset, settle, clock divider, RGB565 output, then terminate.
  localparam logic [15:0] TABLE [DEPTH] = '{
    16'h1280, 16'hFF01, 16'h1101, 16'h1204,
    16'h4010, 16'h3A04, 16'h8C00, END_MARK
  };

  always_ff @(posedge clk) begin
    entry <= (int'(idx) < DEPTH) ? TABLE[idx[2:0]] : END_MARK;
  end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Camera bring-up sequencer: reset pulse, power-up wait, then table-driven SCCB writes and delays.
// Optional CAM_CFG_RETRY_EN adds up to MAX_RETRY NACK retries per write, each after a 1 ms back-off.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int MS_CYCLES   = 12500,
  parameter int RST_CYCLES  = 1250,
  parameter int PWR_WAIT_MS = 2,
  parameter int IDX_W       = 8
`ifdef CAM_CFG_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [IDX_W-1:0]    tbl_idx,
  input  logic [15:0]         tbl_entry,
  cam_cfg_sequencer_if.master sccb,
  output logic                cam_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    err_idx
);

  localparam int CNT_MAX = (RST_CYCLES > MS_CYCLES) ? RST_CYCLES : MS_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MS_LAST  = CNT_W'(MS_CYCLES - 1);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [7:0]         ms_cnt;
  logic [7:0]         ms_target;
  logic               timing;
  logic               ms_tick;
  logic               wait_done;

`ifdef CAM_CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_cnt;
  assign timing = (state == ST_PWR_WAIT) || (state == ST_DLY) || (state == ST_BACKOFF);
`else
  assign timing = (state == ST_PWR_WAIT) || (state == ST_DLY);
`endif

  assign ms_tick   = (cyc_cnt == MS_LAST);
  assign wait_done = ms_tick && (ms_cnt == ms_target - 8'd1);

  // Shared cycle/ms counters: reset-pulse length in RST_LOW, nested ms count in the wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ms_cnt  <= '0;
    end else if (state == ST_RST_LOW) begin
      cyc_cnt <= (cyc_cnt == RST_LAST) ? '0 : cyc_cnt + 1'b1;
      ms_cnt  <= '0;
    end else if (timing) begin
      if (ms_tick) begin
        cyc_cnt <= '0;
        ms_cnt  <= wait_done ? 8'd0 : ms_cnt + 8'd1;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end else begin
      cyc_cnt <= '0;
      ms_cnt  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tbl_idx   <= '0;
      sccb.req  <= 1'b0;
      sccb.addr <= 8'd0;
      sccb.data <= 8'd0;
      cam_rst_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      ms_target <= 8'd0;
`ifdef CAM_CFG_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state     <= ST_RST_LOW;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            tbl_idx   <= '0;
            cam_rst_n <= 1'b0;
          end
        end
        ST_RST_LOW: begin
          if (cyc_cnt == RST_LAST) begin
            cam_rst_n <= 1'b1;
            ms_target <= 8'(PWR_WAIT_MS);
            state     <= (PWR_WAIT_MS == 0) ? ST_FETCH : ST_PWR_WAIT;
          end
        end
        ST_PWR_WAIT: begin
          if (wait_done) state <= ST_FETCH;
        end
        ST_FETCH: state <= ST_DECODE;
        // A DELAY entry of 0 ms skips the wait state entirely.
        ST_DECODE: begin
          if (tbl_entry == END_MARK) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (entry_addr(tbl_entry) == DELAY_ADDR) begin
            ms_target <= entry_data(tbl_entry);
            state     <= (entry_data(tbl_entry) == 8'd0) ? ST_NEXT : ST_DLY;
          end else begin
            sccb.addr <= entry_addr(tbl_entry);
            sccb.data <= entry_data(tbl_entry);
            sccb.req  <= 1'b1;
            state     <= ST_ISSUE;
`ifdef CAM_CFG_RETRY_EN
            retry_cnt <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (sccb.ack) begin
            sccb.req <= 1'b0;
            if (!sccb.nack) begin
              state <= ST_NEXT;
`ifdef CAM_CFG_RETRY_EN
              retry_cnt <= '0;
            end else if (retry_cnt != RETRY_LAST) begin
              retry_cnt <= retry_cnt + 1'b1;
              ms_target <= 8'd1;
              state     <= ST_BACKOFF;
`endif
            end else begin
              state   <= ST_ERROR;
              busy    <= 1'b0;
              err     <= 1'b1;
              err_idx <= tbl_idx;
            end
          end
        end
        ST_DLY: begin
          if (wait_done) state <= ST_NEXT;
        end
`ifdef CAM_CFG_RETRY_EN
        ST_BACKOFF: begin
          if (wait_done) begin
            sccb.req <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
`endif
        // Running off the end of the index space counts as a clean finish.
        ST_NEXT: begin
          if (&tbl_idx) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tbl_idx <= tbl_idx + 1'b1;
            state   <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Randomised bench for cam_cfg_sequencer: table ROM model, SCCB engine model and a walk-the-table reference.
// Builds with or without CAM_CFG_RETRY_EN.
`timescale 1ns/1ps
module tb_cam_cfg_sequencer;
  import cam_cfg_pkg::*;

  localparam int MS_CYCLES   = 50;
  localparam int RST_CYCLES  = 1250;
  localparam int PWR_WAIT_MS = 2;
  localparam int IDX_W       = 8;
`ifdef CAM_CFG_RETRY_EN
  localparam int RETRIES = 3;
`else
  localparam int RETRIES = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] tbl_idx;
  logic [15:0]      tbl_entry;
  logic [15:0]      rom_entry;
  logic [15:0]      model_entry;
  logic             cam_rst_n;
  logic             busy;
  logic             done;
  logic             err;
  logic [IDX_W-1:0] err_idx;

  cam_cfg_sequencer_if sccb_bus();

  cam_cfg_sequencer #(
    .MS_CYCLES  (MS_CYCLES),
    .RST_CYCLES (RST_CYCLES),
    .PWR_WAIT_MS(PWR_WAIT_MS),
    .IDX_W      (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tbl_idx  (tbl_idx),
    .tbl_entry(tbl_entry),
    .sccb     (sccb_bus),
    .cam_rst_n(cam_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_idx  (err_idx)
  );

  cam_cfg_rom #(.IDX_W(IDX_W)) rom (
    .clk  (clk),
    .idx  (tbl_idx),
    .entry(rom_entry)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl_mem [256];
  logic        use_rom;
  logic        nack_plan [16];
  int          nack_len;
  int          eng_fixed;
  logic        spur_en;
  int          seq_id = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic [15:0] exp_q [$];
  int          exp_lb [$];
  logic        exp_done;
  int          exp_idx;

  always @(posedge clk) begin
    model_entry <= tbl_mem[tbl_idx];
    cyc         <= cyc + 1;
  end

  assign tbl_entry = use_rom ? rom_entry : model_entry;

  // SCCB engine model: acks each request after a latency, nack taken from the plan in ack order.
  int eng_seq = -1;
  int eng_cnt;
  int eng_lat;
  int ack_idx;

  always @(negedge clk) begin
    if (eng_seq != seq_id) begin
      eng_seq       = seq_id;
      eng_cnt       = 0;
      ack_idx       = 0;
      eng_lat       = (eng_fixed != 0) ? eng_fixed : int'($urandom_range(1, 6));
      sccb_bus.ack  = 1'b0;
      sccb_bus.nack = 1'b0;
    end else if (sccb_bus.ack) begin
      sccb_bus.ack  = 1'b0;
      sccb_bus.nack = 1'b0;
      eng_cnt       = 0;
    end else if (sccb_bus.req) begin
      eng_cnt++;
      if (eng_cnt >= eng_lat) begin
        sccb_bus.ack  = 1'b1;
        sccb_bus.nack = (ack_idx < nack_len) ? nack_plan[ack_idx] : 1'b0;
        ack_idx++;
        eng_lat = (eng_fixed != 0) ? eng_fixed : int'($urandom_range(1, 6));
      end
    end else begin
      eng_cnt = 0;
      if (spur_en && ($urandom_range(0, 15) == 0)) begin
        sccb_bus.ack  = 1'b1;
        sccb_bus.nack = 1'b1;
      end
    end
  end

  // Request monitor: logs each rising req with its cycle offset from camera reset release.
  int          mon_seq = -1;
  int          low_cnt;
  int          rel_cyc;
  logic        prev_req;
  logic        prev_rst_n;
  logic [15:0] obs_q [$];
  int          obs_t [$];

  always @(negedge clk) begin
    if (mon_seq != seq_id) begin
      mon_seq    = seq_id;
      obs_q.delete();
      obs_t.delete();
      low_cnt    = 0;
      rel_cyc    = 0;
      prev_req   = 1'b0;
      prev_rst_n = 1'b1;
    end
    if (!cam_rst_n) low_cnt++;
    if (cam_rst_n && !prev_rst_n) rel_cyc = cyc;
    if (sccb_bus.req && !prev_req) begin
      obs_q.push_back({sccb_bus.addr, sccb_bus.data});
      obs_t.push_back(cyc - rel_cyc);
    end
    prev_req   = sccb_bus.req;
    prev_rst_n = cam_rst_n;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: walk the table, one request per write attempt, accumulating the minimum ms of waiting.
  task automatic build_expect();
    int          ms_acc;
    int          nk;
    int          tries;
    logic        nacked;
    logic        stop;
    logic [15:0] e;
    exp_q.delete();
    exp_lb.delete();
    ms_acc   = PWR_WAIT_MS;
    nk       = 0;
    exp_done = 1'b1;
    exp_idx  = 255;
    for (int i = 0; i < 256; i++) begin
      e = tbl_mem[i];
      if (e == 16'hFFFF) begin
        exp_idx = i;
        break;
      end
      if (e[15:8] == 8'hFF) begin
        ms_acc += int'(e[7:0]);
        continue;
      end
      tries = 0;
      stop  = 1'b0;
      while (1) begin
        exp_q.push_back(e);
        exp_lb.push_back(ms_acc * MS_CYCLES);
        nacked = (nk < nack_len) ? nack_plan[nk] : 1'b0;
        nk++;
        if (!nacked) break;
        if (tries < RETRIES) begin
          tries++;
          ms_acc++;
        end else begin
          exp_done = 1'b0;
          exp_idx  = i;
          stop     = 1'b1;
          break;
        end
      end
      if (stop) break;
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 256; i++) tbl_mem[i] = 16'($urandom);
    nack_len = 0;
  endtask

  task automatic apply_stimulus(input logic do_reset, input logic mid_start);
    logic timed_out;
    int   n;
    seq_id++;
    if (do_reset) begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    build_expect();
    timed_out = 1'b1;
    for (int k = 0; k < 40000; k++) begin
      start = (mid_start && (k == RST_CYCLES + 20)) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (done || err) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    #1;
    check_output("timeout", 32'(timed_out), 32'd0);
    check_output("rst_low_cycles", 32'(low_cnt), 32'(RST_CYCLES));
    check_output("req_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check_output($sformatf("req%0d_addr_data", k), 32'(obs_q[k]), 32'(exp_q[k]));
      check_output($sformatf("req%0d_min_wait", k), 32'(obs_t[k] >= exp_lb[k]), 32'd1);
    end
    check_output("done", 32'(done), 32'(exp_done));
    check_output("err", 32'(err), 32'(!exp_done));
    check_output("busy", 32'(busy), 32'd0);
    check_output("req_idle", 32'(sccb_bus.req), 32'd0);
    check_output("final_idx", 32'(tbl_idx), 32'(exp_idx));
    if (!exp_done) check_output("err_idx", 32'(err_idx), 32'(exp_idx));
  endtask

  initial begin
    logic req_seen;
    int   len;
    rst       = 1'b1;
    start     = 1'b0;
    use_rom   = 1'b0;
    eng_fixed = 0;
    spur_en   = 1'b0;
    nack_len  = 0;
    clear_table();
    repeat (3) @(negedge clk);
    check_output("rst_tbl_idx", 32'(tbl_idx), 32'd0);
    check_output("rst_req", 32'(sccb_bus.req), 32'd0);
    check_output("rst_addr", 32'(sccb_bus.addr), 32'd0);
    check_output("rst_data", 32'(sccb_bus.data), 32'd0);
    check_output("rst_cam_rst_n", 32'(cam_rst_n), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_err_idx", 32'(err_idx), 32'd0);
    rst = 1'b0;

    $display("[TB] two writes, engine latency 10");
    clear_table();
    tbl_mem[0] = 16'h1280; tbl_mem[1] = 16'h1101; tbl_mem[2] = 16'hFFFF;
    eng_fixed = 10;
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] 5 ms delay before write");
    clear_table();
    tbl_mem[0] = 16'hFF05; tbl_mem[1] = 16'h3A04; tbl_mem[2] = 16'hFFFF;
    eng_fixed = 0;
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] four NACKs on entry 1");
    clear_table();
    tbl_mem[0] = 16'h1280; tbl_mem[1] = 16'h1101; tbl_mem[2] = 16'hFFFF;
    nack_plan[0] = 1'b0;
    for (int i = 1; i < 5; i++) nack_plan[i] = 1'b1;
    nack_len = 5;
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] three NACKs then ACK on entry 1");
    nack_plan[4] = 1'b0;
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] start pulsed during power wait");
    clear_table();
    tbl_mem[0] = 16'h1280; tbl_mem[1] = 16'hFF01; tbl_mem[2] = 16'h1101; tbl_mem[3] = 16'hFFFF;
    apply_stimulus(1'b0, 1'b1);

    $display("[TB] reset during ISSUE");
    clear_table();
    tbl_mem[0] = 16'h1280; tbl_mem[1] = 16'h1101; tbl_mem[2] = 16'hFFFF;
    eng_fixed = 20;
    seq_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    req_seen = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (sccb_bus.req) begin
        req_seen = 1'b1;
        break;
      end
    end
    check_output("req_seen", 32'(req_seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_req", 32'(sccb_bus.req), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_cam_rst_n", 32'(cam_rst_n), 32'd1);
    check_output("midrst_tbl_idx", 32'(tbl_idx), 32'd0);
    rst = 1'b0;
    eng_fixed = 0;
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] built-in OV table");
    clear_table();
    tbl_mem[0] = 16'h1280; tbl_mem[1] = 16'hFF01; tbl_mem[2] = 16'h1101; tbl_mem[3] = 16'h1204;
    tbl_mem[4] = 16'h4010; tbl_mem[5] = 16'h3A04; tbl_mem[6] = 16'h8C00; tbl_mem[7] = 16'hFFFF;
    use_rom = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    use_rom = 1'b0;

    $display("[TB] table without END marker");
    clear_table();
    for (int i = 0; i < 256; i++) tbl_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] random tables");
    spur_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      clear_table();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 2)
          tbl_mem[i] = {8'hFF, 8'($urandom_range(0, 3))};
        else
          tbl_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
      end
      tbl_mem[len] = 16'hFFFF;
      for (int i = 0; i < 16; i++) nack_plan[i] = ($urandom_range(0, 4) == 0);
      nack_len = 16;
      apply_stimulus(1'($urandom_range(0, 1)), 1'b0);
    end
    spur_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
Sequences OV-series camera bring-up. It pulses the camera reset, then walks a register-write table held in an external ROM, issuing one write at a time to the SCCB byte engine through a req/ack handshake. It also honours in-table millisecond delays. It sits between the top level and the SCCB engine, and its done output drives the camera-enable signal that gates the camera capture path.

Parameters:
- MS_CYCLES, 12500: clk cycles per millisecond.
- RST_CYCLES, 1250: cycles cam_rst_n is held low.
- PWR_WAIT_MS, 2: ms to wait after reset release before the first write.
- IDX_W, 8: table index width (max 256 entries).
- MAX_RETRY, 3: NACK retries per entry (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a sequence from IDLE, DONE or ERROR
- tbl_idx  out  IDX_W  ROM address
- tbl_entry  in  16  ROM data {reg_addr[15:8], reg_data[7:0]}, valid 1 cycle after tbl_idx changes
- sccb_req  out  1  write request to SCCB engine
- sccb_addr  out  8  register address
- sccb_data  out  8  register value
- sccb_ack  in  1  one-cycle completion pulse from engine
- sccb_nack  in  1  qualifies sccb_ack: slave did not acknowledge
- cam_rst_n  out  1  camera reset, active-low
- busy  out  1  sequence in progress
- done  out  1  sequence completed successfully (level)
- err  out  1  sequence aborted on NACK (level)
- err_idx  out  IDX_W  entry index that failed

Behaviour:
- Reset values:
  - State IDLE.
  - tbl_idx=0, sccb_req=0, sccb_addr=0, sccb_data=0.
  - cam_rst_n=1, busy=0, done=0, err=0, err_idx=0.
  - All counters 0.
- Entry decode:
  - 16'hFFFF = END.
  - reg_addr 8'hFF with any other data = DELAY of reg_data ms; reg_data 0 means no wait.
  - Anything else = WRITE.
- State machine:
  - IDLE: on start → RST_LOW. Clear done/err, busy=1, tbl_idx=0.
  - RST_LOW: cam_rst_n=0 for RST_CYCLES cycles → PWR_WAIT, with cam_rst_n=1.
  - PWR_WAIT: count PWR_WAIT_MS*MS_CYCLES cycles → FETCH.
  - FETCH: one cycle of ROM latency → DECODE.
  - DECODE:
    - END → DONE.
    - DELAY → DLY.
    - WRITE → ISSUE: latch sccb_addr/sccb_data, sccb_req=1.
  - ISSUE:
    - Hold sccb_req, sccb_addr and sccb_data stable until sccb_ack.
    - On the ack cycle drop sccb_req.
    - If sccb_nack=0 → NEXT.
    - If sccb_nack=1 → ERROR.
  - DLY: count reg_data*MS_CYCLES cycles with a nested ms counter → NEXT.
  - NEXT:
    - If tbl_idx is at all-ones → DONE (table exhausted without END marker is a success).
    - Otherwise increment tbl_idx → FETCH.
  - DONE: busy=0, done=1. A start pulse restarts the full sequence.
  - ERROR: busy=0, err=1, err_idx=tbl_idx. A start pulse restarts.
- Per-write cadence: FETCH, DECODE, ISSUE, NEXT. Minimum 4 cycles per write plus engine latency.
- Edge rules:
  - start while busy: ignored.
  - sccb_ack outside ISSUE: ignored.
  - sccb_ack in the same cycle as DECODE: not possible, because req is not yet asserted.
  - rst during any state, including ISSUE with req high: next cycle all outputs return to reset values. The engine must tolerate req dropping mid-transaction.
- Counter widths: sized for RST_CYCLES and MS_CYCLES; the ms counter is 8 bits. No wrap-around in normal use.

Optional Feature:
- Macro name: CAM_CFG_RETRY_EN.
- When defined:
  - A NACK on a WRITE entry re-enters ISSUE for the same entry, up to MAX_RETRY times.
  - A 1 ms back-off precedes each retry.
  - The retry counter clears on every successful ack and on every new entry.
  - ERROR is entered only after MAX_RETRY+1 consecutive NACKs.
- When undefined: the first NACK goes directly to ERROR, and no retry logic is synthesised.

Decomposition:
- Shared package cam_cfg_pkg holds:
  - the state enum;
  - END_MARK=16'hFFFF and DELAY_ADDR=8'hFF;
  - entry-field slice constants.
- One natural sub-module, cam_cfg_rom: a synchronous ROM with 1-cycle latency holding the OV register table. It is instantiated at top level, not inside the sequencer.

Test Plan:
- Reset release, start pulse, table {0x1280, 0x1101, FFFF}, engine acks with nack=0 after 10 cycles → cam_rst_n low exactly 1250 cycles; two writes (0x12/0x80, then 0x11/0x01); done=1, busy=0, err=0.
- Table {0xFF05, 0x3A04, FFFF} → the 0x3A write is issued ≥5*12500 cycles after the DELAY entry decodes; done=1.
- NACK on entry 1 with retry macro off → err=1, err_idx=1, sccb_req=0, done=0.
- Retry macro on, 3 NACKs then an ACK on entry 1 → 4 requests each carrying the same addr/data; done=1, err=0. With 4 NACKs → err=1.
- rst asserted mid-ISSUE with sccb_req=1 → next cycle sccb_req=0, busy=0, state IDLE. A subsequent start reruns from index 0.
- start pulsed during PWR_WAIT → ignored; the sequence completes once, with no second reset pulse.
